// File: rtl/regfile_access_sequencer.sv
//==============================================================================
// Module      : regfile_access_sequencer
// Description : Serialises decode operand reads and write-back result writes
//               onto a single-port, synchronous-read Y86-64 register storage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_access_sequencer #(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] RSP_ID  = 4'd4,
    parameter logic [3:0] NONE_ID = 4'd15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    // decode read request
    input  logic              dec_req,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    output logic              dec_done,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    // write-back request
    input  logic              wb_req,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              wb_done,
    // register storage port
    output logic [3:0]        rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_E   = 3'd1,
        S_WR_M   = 3'd2,
        S_RD_A   = 3'd3,
        S_RD_B   = 3'd4,
        S_RD_FIN = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [3:0]          r_src_a;
    logic [3:0]          r_src_b;
    logic [3:0]          r_dst_e;
    logic [3:0]          r_dst_m;
    logic [DATA_W-1:0]   r_val_e;
    logic [DATA_W-1:0]   r_val_m;
    logic [DATA_W-1:0]   r_val_a;
    logic [DATA_W-1:0]   r_val_b;
    logic                r_dec_done;
    logic                r_wb_done;

    logic                w_idle;
    logic                w_acc_wb;
    logic                w_acc_dec;
    logic [3:0]          w_src_a;
    logic [3:0]          w_src_b;
    logic [DATA_W-1:0]   w_rd_val;

    assign w_idle    = (r_state == S_IDLE);
    // Write-back wins ties so the following decode sees the retiring results.
    assign w_acc_wb  = w_idle && wb_req;
    assign w_acc_dec = w_idle && dec_req && !wb_req;

    assign ready     = w_idle;
    assign dec_done  = r_dec_done;
    assign wb_done   = r_wb_done;
    assign valA      = r_val_a;
    assign valB      = r_val_b;

    always_comb begin
        w_src_a = NONE_ID;
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_src_a = rA;
            4'h9, 4'hB:             w_src_a = RSP_ID;
            default:                w_src_a = NONE_ID;
        endcase
    end

    always_comb begin
        w_src_b = NONE_ID;
        case (icode)
            4'h4, 4'h5, 4'h6:       w_src_b = rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_src_b = RSP_ID;
            default:                w_src_b = NONE_ID;
        endcase
    end

    // Read data belongs to the address presented in the previous state.
    always_comb begin
        w_rd_val = rf_rdata;
        if ((r_state == S_RD_B) && (r_src_a == NONE_ID)) begin
            w_rd_val = '0;
        end
        if ((r_state == S_RD_FIN) && (r_src_b == NONE_ID)) begin
            w_rd_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rf_addr  = 4'd0;
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_acc_wb) begin
                    w_next = S_WR_E;
                end else if (w_acc_dec) begin
                    w_next = S_RD_A;
                end
            end
            S_WR_E: begin
                rf_addr  = r_dst_e;
                rf_we    = (r_dst_e != NONE_ID);
                rf_wdata = r_val_e;
                w_next   = S_WR_M;
            end
            S_WR_M: begin
                rf_addr  = r_dst_m;
                rf_we    = (r_dst_m != NONE_ID);
                rf_wdata = r_val_m;
                w_next   = S_IDLE;
            end
            S_RD_A: begin
                rf_addr = r_src_a;
                w_next  = S_RD_B;
            end
            S_RD_B: begin
                rf_addr = r_src_b;
                w_next  = S_RD_FIN;
            end
            S_RD_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_a    <= 4'd0;
            r_src_b    <= 4'd0;
            r_dst_e    <= 4'd0;
            r_dst_m    <= 4'd0;
            r_val_e    <= '0;
            r_val_m    <= '0;
            r_val_a    <= '0;
            r_val_b    <= '0;
            r_dec_done <= 1'b0;
            r_wb_done  <= 1'b0;
        end else begin
            if (w_acc_wb) begin
                r_dst_e <= dstE;
                r_val_e <= valE;
                r_dst_m <= dstM;
                r_val_m <= valM;
            end
            if (w_acc_dec) begin
                r_src_a <= w_src_a;
                r_src_b <= w_src_b;
            end
            if (r_state == S_RD_B) begin
                r_val_a <= w_rd_val;
            end
            if (r_state == S_RD_FIN) begin
                r_val_b <= w_rd_val;
            end
            r_dec_done <= (r_state == S_RD_FIN);
            r_wb_done  <= (r_state == S_WR_M);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_sequencer.sv
//==============================================================================
// Module      : tb_regfile_access_sequencer
// Description : Scoreboard bench for regfile_access_sequencer with a local
//               synchronous-read register storage model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_access_sequencer;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        dec_req;
    logic [3:0]  icode, rA, rB;
    logic        dec_done;
    logic [63:0] valA, valB;
    logic        wb_req;
    logic [3:0]  dstE, dstM;
    logic [63:0] valE, valM;
    logic        wb_done;
    logic [3:0]  rf_addr;
    logic        rf_we;
    logic [63:0] rf_wdata;
    logic [63:0] rf_rdata;

    logic [63:0] mem [16];

    typedef struct { logic [3:0] a; logic [63:0] d; } wr_t;
    typedef struct { logic [63:0] va; logic [63:0] vb; } rd_t;

    wr_t wq[$];
    rd_t dq[$];
    int  wbq[$];

    int checks   = 0;
    int failures = 0;

    regfile_access_sequencer dut (
        .clk(clk), .reset(reset), .ready(ready),
        .dec_req(dec_req), .icode(icode), .rA(rA), .rB(rB),
        .dec_done(dec_done), .valA(valA), .valB(valB),
        .wb_req(wb_req), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .wb_done(wb_done),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a write or a done.
    initial begin
        wr_t w;
        rd_t r;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                if (rf_we) begin
                    if (wq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write addr=%0d data=%h", rf_addr, rf_wdata);
                    end else begin
                        w = wq.pop_front();
                        chk("write_addr", {60'd0, rf_addr}, {60'd0, w.a});
                        chk("write_data", rf_wdata, w.d);
                    end
                end
                if (dec_done) begin
                    if (dq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_dec_done actual=1 expected=0");
                    end else begin
                        r = dq.pop_front();
                        chk("valA", valA, r.va);
                        chk("valB", valB, r.vb);
                    end
                end
                if (wb_done) begin
                    checks++;
                    if (wbq.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_wb_done actual=1 expected=0");
                    end else begin
                        void'(wbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic scramble();
        icode = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        dstE = 4'($urandom); dstM = 4'($urandom);
        valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
    endtask

    task automatic do_wb(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        int n;
        wait_ready();
        wb_req = 1'b1; dstE = de; valE = ve; dstM = dm; valM = vm;
        @(posedge clk);
        if (de != 4'd15) wq.push_back('{de, ve});
        if (dm != 4'd15) wq.push_back('{dm, vm});
        wbq.push_back(1);
        #2;
        wb_req = 1'b0;
        scramble();
        n = 0;
        while (!wb_done && n < 10) begin
            @(posedge clk); #2; n++;
        end
        chk("wb_latency", 64'(n), 64'd2);
    endtask

    task automatic do_dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [63:0] ea, input logic [63:0] eb,
                          input logic [3:0] aa, input logic [3:0] ab);
        int n;
        wait_ready();
        dec_req = 1'b1; icode = ic; rA = ra; rB = rb;
        @(posedge clk);
        dq.push_back('{ea, eb});
        #2;
        dec_req = 1'b0;
        scramble();
        n = 0;
        while (!dec_done && n < 10) begin
            if (n == 0) chk("rd_addr_a", {60'd0, rf_addr}, {60'd0, aa});
            if (n == 1) chk("rd_addr_b", {60'd0, rf_addr}, {60'd0, ab});
            @(posedge clk); #2; n++;
        end
        chk("dec_latency", 64'(n), 64'd3);
    endtask

    initial begin
        int  n;
        logic saw_we;
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        mem[0] = 64'd20;
        mem[1] = 64'd21;
        reset = 1'b1; dec_req = 1'b0; wb_req = 1'b0;
        icode = 4'd0; rA = 4'd0; rB = 4'd0;
        dstE = 4'd15; dstM = 4'd15; valE = 64'd0; valM = 64'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready",    {63'd0, ready},    64'd1);
        chk("rst_dec_done", {63'd0, dec_done}, 64'd0);
        chk("rst_wb_done",  {63'd0, wb_done},  64'd0);
        chk("rst_valA", valA, 64'd0);
        chk("rst_valB", valB, 64'd0);
        chk("rst_rf_we",    {63'd0, rf_we},    64'd0);
        chk("rst_rf_addr",  {60'd0, rf_addr},  64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        saw_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (rf_we) saw_we = 1'b1;
        end
        chk("idle_no_we", {63'd0, saw_we}, 64'd0);
        chk("idle_ready", {63'd0, ready},  64'd1);

        do_wb(4'd3, 64'h55, 4'd15, 64'h99);
        do_dec(4'h6, 4'd3, 4'd0, 64'h55, 64'd20, 4'd3, 4'd0);

        // Simultaneous requests: write-back first, pushq decode afterwards.
        wait_ready();
        wb_req = 1'b1; dstE = 4'd4; valE = 64'd100; dstM = 4'd15; valM = 64'd7;
        dec_req = 1'b1; icode = 4'hA; rA = 4'd1; rB = 4'd15;
        @(posedge clk);
        wq.push_back('{4'd4, 64'd100});
        wbq.push_back(1);
        #2;
        wb_req = 1'b0;
        chk("prio_wr_state_we", {63'd0, rf_we}, 64'd1);
        n = 0;
        while (!ready && n < 10) begin
            @(posedge clk); #2; n++;
        end
        @(posedge clk);
        dq.push_back('{64'd21, 64'd100});
        #2;
        dec_req = 1'b0;
        n = 0;
        while (!dec_done && n < 10) begin
            @(posedge clk); #2; n++;
        end
        chk("prio_dec_latency", 64'(n), 64'd3);

        do_wb(4'd7, 64'd1, 4'd7, 64'd2);
        do_dec(4'h2, 4'd7, 4'd0, 64'd2, 64'd0, 4'd7, 4'd15);
        do_dec(4'h3, 4'd1, 4'd0, 64'd0, 64'd0, 4'd15, 4'd15);
        do_dec(4'h0, 4'd3, 4'd1, 64'd0, 64'd0, 4'd15, 4'd15);
        do_dec(4'hC, 4'd1, 4'd0, 64'd0, 64'd0, 4'd15, 4'd15);
        do_dec(4'h5, 4'd1, 4'd0, 64'd0, 64'd20, 4'd15, 4'd0);
        do_dec(4'h8, 4'd1, 4'd3, 64'd0, 64'd100, 4'd15, 4'd4);
        do_dec(4'h9, 4'd0, 4'd0, 64'd100, 64'd100, 4'd4, 4'd4);

        // Reset in WR_E: the WR_E write lands, WR_M and wb_done must not.
        wait_ready();
        wb_req = 1'b1; dstE = 4'd5; valE = 64'hAA; dstM = 4'd6; valM = 64'hBB;
        @(posedge clk);
        wq.push_back('{4'd5, 64'hAA});
        #2;
        wb_req = 1'b0;
        chk("rstmid_wr_e_we", {63'd0, rf_we}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("rstmid_ready", {63'd0, ready}, 64'd1);
        chk("rstmid_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rstmid_valA", valA, 64'd0);
        chk("rstmid_valB", valB, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("reg6_untouched", mem[6], 64'd0);
        chk("reg7_final", mem[7], 64'd2);
        chk("scoreboard_empty", 64'(wq.size() + dq.size() + wbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
